// File: rtl/dwell_driver.sv
// Transmit-side dwell driver: applies level or pulse commands to code_out and
// holds every resulting level for a programmable minimum number of cycles.
module dwell_driver #(
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] Hold_Timer,
  input  logic [31:0] Pulse_Timer,
  input  logic        cmd_valid,
  input  logic        cmd_level,
  input  logic        cmd_pulse,
  output logic        cmd_ready,
  output logic        code_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    DWELL = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] hl, hl_n;
  logic [31:0] pl, pl_n;
  logic        code_n, ready_n, done_n, busy_n;
  logic        accept;

  assign accept = cmd_valid && cmd_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values computed before the edge, independent of statement order.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      code_out  <= INIT_LEVEL;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      code_out  <= code_n;
      cmd_ready <= ready_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // NOTE: the latched timer copies carry no reset; they are always reloaded on
  // accept before any state reads them, so a reset term would only add logic.
  always_ff @(posedge Clk) begin
    hl <= hl_n;
    pl <= pl_n;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hl_n    = hl;
    pl_n    = pl;
    code_n  = code_out;
    ready_n = cmd_ready;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (accept) begin
          hl_n = Hold_Timer;
          pl_n = Pulse_Timer;
          if (cmd_pulse) begin
            code_n  = ~code_out;
            cnt_n   = '0;
            state_n = PULSE;
            ready_n = 1'b0;
          end else if (cmd_level != code_out) begin
            code_n  = cmd_level;
            cnt_n   = '0;
            state_n = DWELL;
            ready_n = 1'b0;
          end else begin
            // Already at the requested level: complete without an edge.
            done_n = 1'b1;
          end
        end
      end

      PULSE: begin
        // Comparing before incrementing keeps cnt at or below the limit,
        // so an all-ones limit cannot overflow.
        if (cnt >= pl) begin
          code_n  = ~code_out;
          cnt_n   = '0;
          state_n = DWELL;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end

      DWELL: begin
        if (cnt >= hl) begin
          cnt_n   = '0;
          state_n = IDLE;
          ready_n = 1'b1;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: doc/dwell_driver.md
# dwell_driver

Drives a single discrete output line so that every level it produces is held long enough to pass a downstream time filter at the far end. It accepts level or pulse commands from the controller through a valid/ready handshake and applies a programmable minimum dwell after every edge. It is the transmit-side counterpart of the input glitch filter and sits between command logic and the output pin register.

## Interface
- INIT_LEVEL, 1'b0, level of code_out after reset.
- Clk  input  1  system clock; all logic on its rising edge.
- Rst_n  input  1  reset, synchronous, active-low.
- Hold_Timer  input  32  minimum dwell count H after any edge of code_out; sampled at command accept.
- Pulse_Timer  input  32  pulse width count P; sampled at command accept.
- cmd_valid  input  1  command present.
- cmd_level  input  1  requested steady level; ignored when cmd_pulse=1.
- cmd_pulse  input  1  1 = pulse command: invert, hold, restore.
- cmd_ready  output  1  block can accept a command; registered.
- code_out  output  1  driven line; registered.
- busy  output  1  state != IDLE; registered.
- done  output  1  one-cycle strobe when a command completes.

## Operation
- States: IDLE, PULSE, DWELL. A single 32-bit counter cnt, plus latched copies Hl and Pl of the timers.
- Accept = cmd_valid && cmd_ready at a rising edge. Only IDLE accepts. Hold_Timer and Pulse_Timer are latched into Hl and Pl on accept. Later changes to the inputs do not affect a command in flight.
- Level command, cmd_level != code_out: code_out <= cmd_level, cnt <= 0, go to DWELL, cmd_ready <= 0.
- Level command, cmd_level == code_out: no edge and no state change. done <= 1 on the accept edge, and cmd_ready stays 1.
- Pulse command: code_out <= ~code_out, cnt <= 0, go to PULSE, cmd_ready <= 0.
- PULSE: while cnt < Pl, cnt <= cnt+1. When cnt >= Pl: code_out <= ~code_out (restore), cnt <= 0, go to DWELL.
- DWELL: while cnt < Hl, cnt <= cnt+1. When cnt >= Hl: go to IDLE, cmd_ready <= 1, done <= 1.
- done is 0 in every cycle other than the ones above.
- Counter arithmetic is unsigned 32-bit with no wrap. cnt never exceeds the latched limit, so a limit of 32'hFFFFFFFF terminates without overflow.
- Timer value 0 is legal and gives the minimum widths listed under Timing.
- The counter alone sets pulse width. The guarantee against a far-end filter with count F is met by programming P >= F and H >= F.
- Reset (Rst_n low at an edge), in any state including mid-pulse or mid-dwell, takes effect on that edge:
  - state IDLE, cnt 0;
  - code_out INIT_LEVEL;
  - cmd_ready 0, busy 0, done 0.
  - The in-flight command is dropped with no done.
- cmd_ready rises on the first edge with Rst_n high.

## Timing
- Reset values: code_out=INIT_LEVEL, cmd_ready=0, busy=0, done=0. First accept is possible at the second edge after Rst_n goes high.
- Accept at edge k changes code_out at edge k, visible in cycle k.
- Level edge: DWELL exits at edge k+H+1. cmd_ready and done are high in cycle k+H+1, so the next accept comes no earlier than edge k+H+1. The new level is therefore held at least H+1 cycles.
- Pulse: the restore edge is at k+P+1, giving an inverted width of exactly P+1 cycles. DWELL exits at k+P+H+2, where done is high.
- Back-to-back commands with cmd_valid held high give gap-free throughput limited only by the dwell.
- done and cmd_ready assert on the same edge. done is high for exactly one cycle per completed command.

## Test plan
- Reset: hold Rst_n=0 for 3 cycles with cmd_valid=1 -> code_out=INIT_LEVEL, cmd_ready=0, done=0. cmd_ready=1 one cycle after release.
- Level edge, H=3: accept level 1 from 0 at edge k -> code_out=1 from cycle k, busy cycles k..k+3, cmd_ready and done high in cycle k+4 only.
- Pulse, P=5, H=2: accept at edge k -> code_out inverted for exactly 6 cycles, restored at k+6, done in cycle k+9.
- Zero timers, P=0, H=0: pulse -> 1-cycle inverted pulse, done 2 cycles after accept. Same-level command -> no edge, done on the accept edge, cmd_ready stays 1.
- Timer change mid-command: accept with H=10, then drive Hold_Timer=1 -> dwell still ends 11 cycles after accept.
- Reset mid-pulse: assert Rst_n=0 at cycle k+2 of a P=8 pulse -> code_out=INIT_LEVEL at that edge, no done. Restart behaves as after the first reset.
